instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 43 ++++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: program-counter handshake, instruction-memory read port
// and the decode-side instruction stream.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  pc;
    logic               pc_en;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               flush;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        input  pc,
        input  imem_rdata,
        input  flush,
        input  instr_ready,
        output pc_en,
        output imem_req,
        output imem_addr,
        output instr,
        output instr_pc,
        output instr_valid
    );

    modport slave (
        output pc,
        output imem_rdata,
        output flush,
        output instr_ready,
        input  pc_en,
        input  imem_req,
        input  imem_addr,
        input  instr,
        input  instr_pc,
        input  instr_valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues single-cycle-latency memory reads at pc and
// queues the returned words with their fetch address for the decode stage.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [INSTR_W-1:0] q_instr_q [DEPTH];
    logic [INSTR_W-1:0] q_instr_d [DEPTH];
    logic [ADDR_W-1:0]  q_pc_q [DEPTH];
    logic [ADDR_W-1:0]  q_pc_d [DEPTH];

    logic               pop_s;
    logic               push_s;
    logic               req_s;
    logic [OW-1:0]      occupancy_s;

    // Request gating: an in-flight read already owns a queue slot, so counting
    // it here is what makes a push into a full queue impossible.
    always_comb begin
        pop_s       = (count_q != CW'(0)) && bus.instr_ready;
        push_s      = inflight_q && !bus.flush;
        occupancy_s = OW'(count_q) + OW'(inflight_q) - OW'(pop_s);
        req_s       = !reset && !bus.flush && (occupancy_s < OW'(DEPTH));
    end

    assign bus.imem_req    = req_s;
    assign bus.pc_en       = req_s;
    assign bus.imem_addr   = bus.pc;
    assign bus.instr       = q_instr_q[rd_ptr_q];
    assign bus.instr_pc    = q_pc_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != CW'(0));

    // Next-state for queue, pointers and in-flight tracker; flush wins over push/pop.
    always_comb begin
        q_instr_d     = q_instr_q;
        q_pc_d        = q_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        if (bus.flush) begin
            count_d    = CW'(0);
            rd_ptr_d   = PW'(0);
            wr_ptr_d   = PW'(0);
            inflight_d = 1'b0;
        end else begin
            inflight_d    = req_s;
            inflight_pc_d = req_s ? bus.pc : inflight_pc_q;
            if (push_s) begin
                q_instr_d[wr_ptr_q] = bus.imem_rdata;
                q_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers with synchronous reset; queue contents cleared so the
    // head reads as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= CW'(0);
            rd_ptr_q      <= PW'(0);
            wr_ptr_q      <= PW'(0);
            inflight_q    <= 1'b0;
            inflight_pc_q <= ADDR_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= INSTR_W'(0);
                q_pc_q[i]    <= ADDR_W'(0);
            end
        end else begin
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            q_instr_q     <= q_instr_d;
            q_pc_q        <= q_pc_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a PC register and a one-cycle memory
// (word = 0x1000 + addr) are modelled around the fetch stage.
module tb_instruction_fetch;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   req_count;

    instruction_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instruction_fetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers last cycle's request, PC advances on pc_en.
    task automatic tick();
        logic       r;
        logic       pe;
        logic [7:0] a;
        r  = bus.imem_req;
        pe = bus.pc_en;
        a  = bus.imem_addr;
        @(posedge clk);
        #1;
        if (r) begin
            bus.imem_rdata = 16'h1000 + {8'h00, a};
            req_count++;
        end else begin
            bus.imem_rdata = 16'hDEAD;
        end
        if (pe) begin
            bus.pc = bus.pc + 8'd1;
        end
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] ei, input logic [7:0] ep);
        chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        chk({tag, "_instr"}, {16'd0, bus.instr}, {16'd0, ei});
        chk({tag, "_pc"}, {24'd0, bus.instr_pc}, {24'd0, ep});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        req_count = 0;
        reset = 1'b1;
        bus.pc = 8'h00;
        bus.flush = 1'b0;
        bus.instr_ready = 1'b1;
        bus.imem_rdata = 16'h0000;
        #1;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pcen", {31'd0, bus.pc_en}, 32'd0);
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("rst_ipc", {24'd0, bus.instr_pc}, 32'd0);

        // Streaming with decode always ready
        reset = 1'b0;
        #1;
        chk("s_req0", {31'd0, bus.imem_req}, 32'd1);
        chk("s_pcen0", {31'd0, bus.pc_en}, 32'd1);
        chk("s_addr0", {24'd0, bus.imem_addr}, 32'h00);
        tick();
        chk("s_lat_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk_head("s_first", 16'h1000, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_head("s_stream", 16'h1000 + 16'(i), 8'(i));
            chk("s_req", {31'd0, bus.imem_req}, 32'd1);
        end

        // Fill with decode stalled
        reset = 1'b1;
        bus.pc = 8'h00;
        bus.instr_ready = 1'b0;
        #1;
        chk("r_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        req_count = 0;
        #1;
        chk("f_addr0", {24'd0, bus.imem_addr}, 32'h00);
        tick();
        chk("f_valid1", {31'd0, bus.instr_valid}, 32'd0);
        chk("f_addr1", {24'd0, bus.imem_addr}, 32'h01);
        tick();
        chk_head("f_head2", 16'h1000, 8'h00);
        chk("f_req2", {31'd0, bus.imem_req}, 32'd0);
        chk("f_pcen2", {31'd0, bus.pc_en}, 32'd0);
        tick();
        tick();
        chk_head("f_hold", 16'h1000, 8'h00);
        chk("f_req4", {31'd0, bus.imem_req}, 32'd0);
        chk("f_nreq", req_count, 32'd2);

        // Single pop from a full queue
        bus.instr_ready = 1'b1;
        #1;
        chk("p_req", {31'd0, bus.imem_req}, 32'd1);
        chk("p_addr", {24'd0, bus.imem_addr}, 32'h02);
        tick();
        bus.instr_ready = 1'b0;
        #1;
        chk_head("p_head", 16'h1001, 8'h01);
        chk("p_req_hold", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk_head("p_stable", 16'h1001, 8'h01);
        bus.instr_ready = 1'b1;
        #1;
        tick();
        bus.instr_ready = 1'b0;
        #1;
        chk_head("p_order", 16'h1002, 8'h02);
        chk("p_req_inf", {31'd0, bus.imem_req}, 32'd0);

        // Flush with an entry queued and a read in flight
        bus.flush = 1'b1;
        #1;
        chk("fl_req", {31'd0, bus.imem_req}, 32'd0);
        chk("fl_pcen", {31'd0, bus.pc_en}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("fl_req_after", {31'd0, bus.imem_req}, 32'd1);
        chk("fl_addr", {24'd0, bus.imem_addr}, 32'h04);
        tick();
        chk("fl_valid2", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk_head("fl_next", 16'h1004, 8'h04);
        tick();
        chk("fl_full_req", {31'd0, bus.imem_req}, 32'd0);
        chk_head("fl_full_head", 16'h1004, 8'h04);

        // Reset pulse while full
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        chk("rp_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rp_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rp_addr", {24'd0, bus.imem_addr}, 32'h06);
        tick();
        tick();
        chk_head("rp_head", 16'h1006, 8'h06);

        // PC wrap
        reset = 1'b1;
        bus.pc = 8'hFE;
        bus.instr_ready = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        chk("w_addr", {24'd0, bus.imem_addr}, 32'hFE);
        tick();
        tick();
        chk_head("w_fe", 16'h10FE, 8'hFE);
        tick();
        chk_head("w_ff", 16'h10FF, 8'hFF);
        tick();
        chk_head("w_00", 16'h1000, 8'h00);

        // Flush together with pop and push
        bus.flush = 1'b1;
        #1;
        chk("fp_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fp_valid", {31'd0, bus.instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
